// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side signals around the memory bus arbiter.
// The master modport is the arbiter's own view: it owns the memory request and
// the requester completions. The slave modport is the surrounding logic
// (fetch unit, load/store unit and memory interconnect).
interface mem_bus_arbiter_if;
   // instruction fetch port (read-only)
   logic        ifu_req_i;
   logic [31:0] ifu_addr_i;
   logic [31:0] ifu_rdata_o;
   logic        ifu_ack_o;
   // load/store port
   logic        lsu_sel_i;
   logic        lsu_wen_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic [3:0]  lsu_wmask_i;
   logic [31:0] lsu_rdata_o;
   logic        lsu_ack_o;
   logic        ls_hold_o;
   // shared memory bus
   logic        mem_req_o;
   logic        mem_wen_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_wmask_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ack_i;
   logic        bus_err_o;

   modport master (
      input  ifu_req_i, ifu_addr_i,
      input  lsu_sel_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
      input  mem_rdata_i, mem_ack_i,
      output ifu_rdata_o, ifu_ack_o,
      output lsu_rdata_o, lsu_ack_o, ls_hold_o,
      output mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      output bus_err_o
   );

   modport slave (
      output ifu_req_i, ifu_addr_i,
      output lsu_sel_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
      output mem_rdata_i, mem_ack_i,
      input  ifu_rdata_o, ifu_ack_o,
      input  lsu_rdata_o, lsu_ack_o, ls_hold_o,
      input  mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
      input  bus_err_o
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-ported memory bus between the
// instruction fetch unit and the load/store unit. One transaction is in flight
// at a time; the bus request is aborted with a bus error pulse if memory does
// not answer within TIMEOUT cycles.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 256,   // cycles mem_req_o may stay high unanswered (>= 2)
   parameter int CNT_W   = 9      // wide enough to hold TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IFU_BUSY = 2'd1,
      LSU_BUSY = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic             GRANT_IFU = 1'b0;
   localparam logic             GRANT_LSU = 1'b1;

   state_t           state_reg, state_next;
   logic             last_grant_reg, last_grant_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [31:0]      addr_reg, addr_next;
   logic [31:0]      wdata_reg, wdata_next;
   logic [3:0]       wmask_reg, wmask_next;
   logic             wen_reg, wen_next;

   logic busy;       // a transaction owns the bus
   logic expired;    // last permitted cycle of the transaction
   logic abort;      // timeout with no answer from memory this cycle
   logic finish;     // transaction ends this cycle (ack or abort)
   logic pick_lsu;   // IDLE arbitration result
   logic pick_ifu;

   assign busy    = (state_reg != IDLE);
   assign expired = busy && (cnt_reg == CNT_LAST);
   assign abort   = expired && !bus.mem_ack_i;
   assign finish  = busy && (bus.mem_ack_i || expired);

   // Under contention the requester that did not win last time goes first.
   assign pick_lsu = bus.lsu_sel_i && (!bus.ifu_req_i || (last_grant_reg == GRANT_IFU));
   assign pick_ifu = bus.ifu_req_i && !pick_lsu;

   // State and captured-bus registers; reset drops the bus request at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= GRANT_IFU;
         cnt_reg        <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         wmask_reg      <= '0;
         wen_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         wmask_reg      <= wmask_next;
         wen_reg        <= wen_next;
      end
   end

   // Next-state logic: grant in IDLE, wait for ack or timeout while busy.
   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      wmask_next      = wmask_reg;
      wen_next        = wen_reg;

      unique case (state_reg)
         IDLE: begin
            if (pick_lsu) begin
               state_next      = LSU_BUSY;
               last_grant_next = GRANT_LSU;
               cnt_next        = '0;
               addr_next       = bus.lsu_addr_i;
               wdata_next      = bus.lsu_wdata_i;
               wen_next        = bus.lsu_wen_i;
               // byte enables only mean something on a store
               wmask_next      = bus.lsu_wen_i ? bus.lsu_wmask_i : 4'b0000;
            end else if (pick_ifu) begin
               state_next      = IFU_BUSY;
               last_grant_next = GRANT_IFU;
               cnt_next        = '0;
               addr_next       = bus.ifu_addr_i;
               wdata_next      = '0;
               wen_next        = 1'b0;
               wmask_next      = 4'b0000;
            end
         end
         IFU_BUSY, LSU_BUSY: begin
            if (finish) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Completion strobes with read-data pass-through; an aborted access returns zero.
   always_comb begin
      bus.ifu_ack_o   = (state_reg == IFU_BUSY) && finish;
      bus.lsu_ack_o   = (state_reg == LSU_BUSY) && finish;
      bus.ifu_rdata_o = '0;
      bus.lsu_rdata_o = '0;
      if ((state_reg == IFU_BUSY) && bus.mem_ack_i) begin
         bus.ifu_rdata_o = bus.mem_rdata_i;
      end
      if ((state_reg == LSU_BUSY) && bus.mem_ack_i) begin
         bus.lsu_rdata_o = bus.mem_rdata_i;
      end
   end

   assign bus.ls_hold_o   = bus.lsu_sel_i && !bus.lsu_ack_o;
   assign bus.bus_err_o   = abort;
   assign bus.mem_req_o   = busy;
   assign bus.mem_wen_o   = wen_reg;
   assign bus.mem_addr_o  = addr_reg;
   assign bus.mem_wdata_o = wdata_reg;
   assign bus.mem_wmask_o = wmask_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: directed scenarios plus random rounds,
// each transaction checked against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   int   n_txn;

   // transaction-level model: outstanding requests and who won last
   bit          ifu_pend;
   bit          lsu_pend;
   logic [31:0] ifu_a;
   logic [31:0] lsu_a;
   logic [31:0] lsu_d;
   logic [3:0]  lsu_m;
   bit          lsu_w;
   bit          last_lsu;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(
      .TIMEOUT (256),
      .CNT_W   (9)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic post_ifu(input logic [31:0] addr);
      ifu_pend       = 1'b1;
      ifu_a          = addr;
      bus.ifu_req_i  = 1'b1;
      bus.ifu_addr_i = addr;
   endtask

   task automatic post_lsu(input logic [31:0] addr, input bit wen,
                           input logic [31:0] wdata, input logic [3:0] mask);
      lsu_pend        = 1'b1;
      lsu_a           = addr;
      lsu_w           = wen;
      lsu_d           = wdata;
      lsu_m           = mask;
      bus.lsu_sel_i   = 1'b1;
      bus.lsu_addr_i  = addr;
      bus.lsu_wen_i   = wen;
      bus.lsu_wdata_i = wdata;
      bus.lsu_wmask_i = mask;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_req",   32'(bus.mem_req_o), 0);
      chk("rst_wen",   32'(bus.mem_wen_o), 0);
      chk("rst_addr",  bus.mem_addr_o, 0);
      chk("rst_wmask", 32'(bus.mem_wmask_o), 0);
      chk("rst_acks",  32'({bus.ifu_ack_o, bus.lsu_ack_o, bus.bus_err_o}), 0);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      last_lsu = 1'b0;
   endtask

   // Called at the falling edge of an IDLE cycle with the pending requests driven.
   // Memory answers after dly cycles of waiting with read data rd.
   task automatic serve(input int dly, input logic [31:0] rd);
      bit          win_lsu;
      bit          wr;
      logic [31:0] exp_addr;
      #1;
      win_lsu  = lsu_pend && (!ifu_pend || !last_lsu);
      wr       = win_lsu && lsu_w;
      exp_addr = win_lsu ? lsu_a : ifu_a;
      chk("idle_req", 32'(bus.mem_req_o), 0);
      chk("hold_pre", 32'(bus.ls_hold_o), 32'(lsu_pend));
      @(posedge clk);
      @(negedge clk);
      chk("req_up", 32'(bus.mem_req_o), 1);
      chk("addr",   bus.mem_addr_o, exp_addr);
      chk("wen",    32'(bus.mem_wen_o), 32'(wr));
      chk("wmask",  32'(bus.mem_wmask_o), wr ? 32'(lsu_m) : 0);
      if (wr) chk("wdata", bus.mem_wdata_o, lsu_d);
      for (int k = 0; k < dly; k++) begin
         chk("early_ack", 32'({bus.ifu_ack_o, bus.lsu_ack_o}), 0);
         chk("req_held",  32'(bus.mem_req_o), 1);
         chk("addr_held", bus.mem_addr_o, exp_addr);
         @(negedge clk);
      end
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = rd;
      #1;
      chk("ifu_ack",   32'(bus.ifu_ack_o), 32'(!win_lsu));
      chk("lsu_ack",   32'(bus.lsu_ack_o), 32'(win_lsu));
      chk("ifu_rdata", bus.ifu_rdata_o, win_lsu ? 32'h0 : rd);
      chk("lsu_rdata", bus.lsu_rdata_o, win_lsu ? rd : 32'h0);
      chk("no_err",    32'(bus.bus_err_o), 0);
      chk("hold_ack",  32'(bus.ls_hold_o), 32'(lsu_pend && !win_lsu));
      @(posedge clk);
      @(negedge clk);
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = $urandom;
      if (win_lsu) begin
         lsu_pend      = 1'b0;
         bus.lsu_sel_i = 1'b0;
      end else begin
         ifu_pend      = 1'b0;
         bus.ifu_req_i = 1'b0;
      end
      last_lsu = win_lsu;
      #1;
      chk("gap_req",  32'(bus.mem_req_o), 0);
      chk("gap_acks", 32'({bus.ifu_ack_o, bus.lsu_ack_o}), 0);
      n_txn++;
      $display("txn %0d: %s %s addr=0x%08h dly=%0d rdata=0x%08h", n_txn,
               win_lsu ? "LSU" : "IFU", wr ? "store" : "load ", exp_addr, dly, rd);
   endtask

   // Memory never answers an LSU load; expect an abort after exactly 256 cycles.
   task automatic timeout_case();
      int high;
      int ack_at;
      int err_at;
      int bad_rd;
      high   = 0;
      ack_at = -1;
      err_at = -1;
      bad_rd = 0;
      post_lsu(32'h0000_0300, 1'b0, 32'h0, 4'h0);
      bus.mem_rdata_i = 32'hA5A5_A5A5;
      @(posedge clk);
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (!bus.mem_req_o) break;
         high = c;
         if (bus.lsu_ack_o) ack_at = c;
         if (bus.bus_err_o) err_at = c;
         if (bus.lsu_ack_o && (bus.lsu_rdata_o != 32'h0)) bad_rd++;
      end
      chk("to_req_cycles", 32'(high), 256);
      chk("to_ack_cycle",  32'(ack_at), 256);
      chk("to_err_cycle",  32'(err_at), 256);
      chk("to_rdata_zero", 32'(bad_rd), 0);
      lsu_pend      = 1'b0;
      bus.lsu_sel_i = 1'b0;
      last_lsu      = 1'b1;
      bus.mem_ack_i = 1'b1;
      #1;
      chk("late_ack_acks", 32'({bus.ifu_ack_o, bus.lsu_ack_o}), 0);
      chk("late_ack_err",  32'(bus.bus_err_o), 0);
      @(negedge clk);
      chk("late_ack_req",  32'(bus.mem_req_o), 0);
      bus.mem_ack_i = 1'b0;
      $display("txn timeout: LSU load addr=0x00000300 req_cycles=%0d ack_at=%0d err_at=%0d",
               high, ack_at, err_at);
   endtask

   // Reset asserted mid-transaction; the held request must be re-granted afterwards.
   task automatic reset_case();
      post_lsu(32'h0000_0400, 1'b1, 32'hCAFE_F00D, 4'b0011);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_req", 32'(bus.mem_req_o), 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req_drop", 32'(bus.mem_req_o), 0);
      chk("async_ack",      32'(bus.lsu_ack_o), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      last_lsu = 1'b0;
      $display("txn reset: LSU_BUSY interrupted by rst_n");
      serve(1, 32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_txn    = 0;
      ifu_pend = 1'b0;
      lsu_pend = 1'b0;
      ifu_a    = '0;
      lsu_a    = '0;
      lsu_d    = '0;
      lsu_m    = '0;
      lsu_w    = 1'b0;
      last_lsu = 1'b0;
      rst_n           = 1'b0;
      bus.ifu_req_i   = 1'b0;
      bus.ifu_addr_i  = '0;
      bus.lsu_sel_i   = 1'b0;
      bus.lsu_wen_i   = 1'b0;
      bus.lsu_addr_i  = '0;
      bus.lsu_wdata_i = '0;
      bus.lsu_wmask_i = '0;
      bus.mem_rdata_i = '0;
      bus.mem_ack_i   = 1'b0;
      @(negedge clk);
      do_reset();

      // contention straight out of reset: LSU first, then IFU
      post_ifu(32'h0000_0000);
      post_lsu(32'h0000_0200, 1'b0, 32'h0, 4'h0);
      serve(1, 32'h1111_2222);
      serve(2, 32'h3333_4444);

      // both requesters kept busy for eight transactions
      for (int i = 0; i < 8; i++) begin
         if (!ifu_pend) post_ifu(32'h0000_1000 + 32'(i * 4));
         if (!lsu_pend) post_lsu(32'h0000_2000 + 32'(i * 4), 1'(i % 2), $urandom, 4'($urandom));
         serve(i % 3, $urandom);
      end
      while (ifu_pend || lsu_pend) serve(0, $urandom);

      // load answered in the same cycle the bus request rises
      post_lsu(32'h0000_0500, 1'b0, 32'h0, 4'h0);
      serve(0, 32'h1234_5678);

      // store answered three cycles late
      post_lsu(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 4'b1111);
      serve(3, $urandom);

      timeout_case();
      reset_case();

      // random traffic
      for (int i = 0; i < 40; i++) begin
         if (!ifu_pend && ($urandom_range(0, 1) == 1)) post_ifu($urandom & 32'hFFFF_FFFC);
         if (!lsu_pend && ($urandom_range(0, 1) == 1))
            post_lsu($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
         if (!ifu_pend && !lsu_pend) post_ifu($urandom & 32'hFFFF_FFFC);
         serve($urandom_range(0, 4), $urandom);
      end
      while (ifu_pend || lsu_pend) serve(0, $urandom);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
